// File: rtl/alu_pkg.sv
// Shared decode constants and the issue-entry record for the ALU issue stage.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SLL   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SR    = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b110;
  localparam logic [2:0] ALU_AND   = 3'b111;

  typedef struct packed {
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;
  } issue_ent_t;

  // Idle/illegal shape: pass-b of a zero operand, nothing written.
  function automatic issue_ent_t ent_idle();
    issue_ent_t e;
    e           = '0;
    e.ctr       = {1'b0, ALU_PASSB};
    return e;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decode; branch decode under ALU_ISSUE_BRANCH_EN.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output issue_ent_t  ent_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_rs_idx;

  assign opc           = instr_i[6:0];
  assign f3            = instr_i[14:12];
  assign unused_rs_idx = ^instr_i[19:15];

  always_comb begin
    ent_o    = ent_idle();
    ent_o.rd = instr_i[11:7];
    case (opc)
      OPC_OP: begin
        ent_o.ctr = {instr_i[30] & ((f3 == F3_ADD) || (f3 == F3_SR)), f3};
        if (f3 == F3_SLTU) ent_o.ctr = {1'b1, ALU_SLT};
        ent_o.a  = rs1_i;
        ent_o.b  = rs2_i;
        ent_o.we = 1'b1;
      end
      OPC_OPIMM: begin
        // Immediate low bits already carry shamt, so shifts need no special b.
        ent_o.ctr = {instr_i[30] & (f3 == F3_SR), f3};
        if (f3 == F3_SLTU) ent_o.ctr = {1'b1, ALU_SLT};
        ent_o.a  = rs1_i;
        ent_o.b  = {{20{instr_i[31]}}, instr_i[31:20]};
        ent_o.we = 1'b1;
      end
      OPC_LUI: begin
        ent_o.ctr = {1'b0, ALU_PASSB};
        ent_o.b   = {instr_i[31:12], 12'b0};
        ent_o.we  = 1'b1;
      end
      OPC_AUIPC: begin
        ent_o.ctr = {1'b0, ALU_ADD};
        ent_o.a   = pc_i;
        ent_o.b   = {instr_i[31:12], 12'b0};
        ent_o.we  = 1'b1;
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT ||
            f3 == F3_BGE || f3 == F3_BLTU || f3 == F3_BGEU) begin
          ent_o.a         = rs1_i;
          ent_o.b         = rs2_i;
          ent_o.is_branch = 1'b1;
          ent_o.br_funct3 = f3;
          if (f3 == F3_BEQ || f3 == F3_BNE)      ent_o.ctr = {1'b1, ALU_ADD};
          else if (f3 == F3_BLT || f3 == F3_BGE) ent_o.ctr = {1'b0, ALU_SLT};
          else                                   ent_o.ctr = {1'b1, ALU_SLT};
        end else begin
          ent_o.illegal = 1'b1;
        end
      end
`endif
      default: ent_o.illegal = 1'b1;
    endcase
    if (ent_o.rd == 5'd0) ent_o.we = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode feeding a two-entry skid buffer with registered in_ready.
// Optional branch decode is enabled by defining ALU_ISSUE_BRANCH_EN.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctr,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_is_branch,
  output logic [2:0]      out_br_funct3,
  output logic            out_illegal
);

  issue_ent_t dec;
  issue_ent_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       acc, drn;

  alu_decode u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .rs1_i   (in_rs1_data),
    .rs2_i   (in_rs2_data),
    .ent_o   (dec)
  );

  assign acc = in_valid & in_ready_q;
  assign drn = (cnt_q != 2'd0) & out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: if (acc) begin
          ent0_d = dec;
          cnt_d  = 2'd1;
        end
        2'd1: begin
          // Accept while draining refills the head directly: no bubble.
          if (acc && drn)  ent0_d = dec;
          else if (acc) begin
            ent1_d = dec;
            cnt_d  = 2'd2;
          end else if (drn) cnt_d = 2'd0;
        end
        default: if (drn) begin
          ent0_d = ent1_q;
          cnt_d  = 2'd1;
        end
      endcase
    end
    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q     <= ent_idle();
      ent1_q     <= ent_idle();
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (cnt_q != 2'd0);
  assign out_alu_ctr   = ent0_q.ctr;
  assign out_a         = ent0_q.a;
  assign out_b         = ent0_q.b;
  assign out_rd        = ent0_q.rd;
  assign out_we        = ent0_q.we;
  assign out_is_branch = ent0_q.is_branch;
  assign out_br_funct3 = ent0_q.br_funct3;
  assign out_illegal   = ent0_q.illegal;

endmodule
